gobou_layer_seq: RTL

- Multi-layer sequencer in front of gobou_ctrl_core: runs a chain of fully-connected layers without host involvement between layers.
- Holds a small layer descriptor table written by the host (total_out, total_in, net_addr per layer).
- Issues one req/ack transaction per layer to the core and ping-pongs image buffers: layer k's output region becomes layer k+1's input region.
- Sits between the host control registers and gobou_ctrl_core.

---
 rtl/gobou_seq_pkg.sv | 24 ++
 rtl/gobou_layer_table.sv | 24 ++
 rtl/gobou_layer_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gobou_seq_pkg.sv
// Shared types and sizes for the gobou multi-layer sequencer.
package gobou_seq_pkg;

  localparam int unsigned LWIDTH        = 16;
  localparam int unsigned IMGSIZE       = 12;
  localparam int unsigned GOBOU_NETSIZE = 11;
  localparam int unsigned MAXLAYER      = 8;
  localparam int unsigned LAYERLOG      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_LO,
    S_WAIT_HI
  } seq_state_t;

  typedef struct packed {
    logic [LWIDTH-1:0]        total_out;
    logic [LWIDTH-1:0]        total_in;
    logic [GOBOU_NETSIZE-1:0] net_addr;
  } layer_desc_t;

endpackage

// File: rtl/gobou_layer_table.sv
// Layer descriptor register file: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (host write), raddr/rdata_c (combinational read).
// Contents are not reset; the host must program them before a run.
module gobou_layer_table
  import gobou_seq_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [LAYERLOG-1:0] waddr,
  input  layer_desc_t         wdata,
  input  logic [LAYERLOG-1:0] raddr,
  output layer_desc_t         rdata_c
);

  layer_desc_t mem [MAXLAYER];

  // Host write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/gobou_layer_seq.sv
// Multi-layer sequencer in front of gobou_ctrl_core. Runs num_layer layers
// back to back, one req/ack handshake per layer, ping-ponging image regions
// A and B between layer input and output.
// Ports: clk/xrst (async active-low); cfg_* descriptor write port; start,
// num_layer, base_a, base_b run control; core_ack in / core_* out to the core;
// busy, done (1-cycle pulse), cur_layer, err (sticky invalid-start flag).
module gobou_layer_seq
  import gobou_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     cfg_we,
  input  logic [LAYERLOG-1:0]      cfg_addr,
  input  logic [LWIDTH-1:0]        cfg_total_out,
  input  logic [LWIDTH-1:0]        cfg_total_in,
  input  logic [GOBOU_NETSIZE-1:0] cfg_net_addr,
  input  logic                     start,
  input  logic [LAYERLOG:0]        num_layer,
  input  logic [IMGSIZE-1:0]       base_a,
  input  logic [IMGSIZE-1:0]       base_b,
  input  logic                     core_ack,
  output logic                     core_req,
  output logic [IMGSIZE-1:0]       core_input_addr,
  output logic [IMGSIZE-1:0]       core_output_addr,
  output logic [GOBOU_NETSIZE-1:0] core_net_addr,
  output logic [LWIDTH-1:0]        core_total_out,
  output logic [LWIDTH-1:0]        core_total_in,
  output logic                     busy,
  output logic                     done,
  output logic [LAYERLOG-1:0]      cur_layer,
  output logic                     err
);

  seq_state_t               state_q, state_d;
  // One bit wider than LAYERLOG so a full MAXLAYER run compares without wrap
  logic [LAYERLOG:0]        layer_q, layer_d;
  logic [LAYERLOG:0]        num_q, num_d;
  logic                     sel_q, sel_d;
  logic                     req_q, req_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [IMGSIZE-1:0]       in_q, in_d, out_q, out_d;
  layer_desc_t              desc_q, desc_d;
  layer_desc_t              rd_desc_c;
  layer_desc_t              wr_desc_c;
  logic                     num_ok_c;

  assign wr_desc_c = '{total_out: cfg_total_out, total_in: cfg_total_in,
                       net_addr: cfg_net_addr};

  gobou_layer_table u_table (
    .clk     (clk),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wdata   (wr_desc_c),
    .raddr   (layer_q[LAYERLOG-1:0]),
    .rdata_c (rd_desc_c)
  );

  assign num_ok_c = (num_layer != '0) &&
                    (num_layer <= (LAYERLOG+1)'(MAXLAYER));

  // State and output registers
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      num_q   <= '0;
      sel_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      in_q    <= '0;
      out_q   <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      num_q   <= num_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      in_q    <= in_d;
      out_q   <= out_d;
      desc_q  <= desc_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    num_d   = num_q;
    sel_d   = sel_q;
    req_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    in_d    = in_q;
    out_d   = out_q;
    desc_d  = desc_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high in the done cycle; a start there is dropped
        if (start && !busy_q) begin
          if (!num_ok_c) begin
            err_d = 1'b1;
          end else if (core_ack) begin
            err_d   = 1'b0;
            num_d   = num_layer;
            layer_d = '0;
            sel_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        desc_d  = rd_desc_c;
        in_d    = sel_q ? base_b : base_a;
        out_d   = sel_q ? base_a : base_b;
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!core_ack) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (core_ack) begin
          if ((LAYERLOG+1)'(layer_q + 1'b1) == num_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            layer_d = (LAYERLOG+1)'(layer_q + 1'b1);
            sel_d   = ~sel_q;
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign core_req         = req_q;
  assign core_input_addr  = in_q;
  assign core_output_addr = out_q;
  assign core_net_addr    = desc_q.net_addr;
  assign core_total_out   = desc_q.total_out;
  assign core_total_in    = desc_q.total_in;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cur_layer        = layer_q[LAYERLOG-1:0];
  assign err              = err_q;

endmodule
